// File: rtl/mem_access_stage.sv
// Memory-access stage and MEM/WB pipeline register of the 64-bit pipelined core.
// The stage runs one instruction at a time. Non-memory ops retire on the edge
// that accepts them. Loads and stores occupy the stage for MEM_LATENCY cycles
// and then access the internal data memory on the retiring edge. While a memory
// op is in flight, ex_ready is low so the upstream stage holds its inputs.
module mem_access_stage #(
  parameter int DEPTH       = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic        flush,
  output logic        wb_valid,
  output logic [63:0] wb_read_data,
  output logic [63:0] wb_alu_output,
  output logic [4:0]  wb_write_reg,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic        mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // An access faults when it is not doubleword aligned or its word index is
  // beyond the end of the array; the whole upper address is range-checked.
  function automatic logic access_err(input logic [63:0] addr);
    return (addr[2:0] != 3'd0) || ((addr >> 3) >= 64'(DEPTH));
  endfunction

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [63:0]   addr_r;
  logic [63:0]   store_data_r;
  logic [4:0]    rd_r;
  logic          load_r;
  logic          store_r;
  logic          mem_to_reg_r;
  logic          reg_write_r;

  logic          wb_valid_r;
  logic [63:0]   wb_read_data_r;
  logic [63:0]   wb_alu_output_r;
  logic [4:0]    wb_write_reg_r;
  logic          wb_mem_to_reg_r;
  logic          wb_reg_write_r;
  logic          mem_err_r;

  logic [63:0]   mem_r [DEPTH];

  logic          ex_mem_op_s;
  logic          finish_s;
  logic          err_s;
  logic [AW-1:0] idx_s;
  logic [63:0]   load_data_s;
  logic          do_store_s;

  // Decode the in-flight access: word index, fault status, load data and the
  // store strobe for the retiring edge (suppressed by reset, flush or fault).
  always_comb begin
    ex_mem_op_s = ex_mem_read | ex_mem_write;
    finish_s    = (state_r == ST_BUSY) && (cnt_r == {CW{1'b0}});
    err_s       = access_err(addr_r);
    idx_s       = addr_r[AW+2:3];
    if (err_s) begin
      load_data_s = 64'd0;
    end else begin
      load_data_s = mem_r[idx_s];
    end
    do_store_s  = finish_s & store_r & ~err_s & ~rst & ~flush;
  end

  // Data memory array; never reset, written only by a retiring, fault-free store.
  always_ff @(posedge clk) begin
    if (do_store_s) begin
      mem_r[idx_s] <= store_data_r;
    end
  end

  // Stage control, in-flight operand capture and the MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= {CW{1'b0}};
      addr_r          <= 64'd0;
      store_data_r    <= 64'd0;
      rd_r            <= 5'd0;
      load_r          <= 1'b0;
      store_r         <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      reg_write_r     <= 1'b0;
      wb_valid_r      <= 1'b0;
      wb_read_data_r  <= 64'd0;
      wb_alu_output_r <= 64'd0;
      wb_write_reg_r  <= 5'd0;
      wb_mem_to_reg_r <= 1'b0;
      wb_reg_write_r  <= 1'b0;
      mem_err_r       <= 1'b0;
    end else if (flush) begin
      // Abort whatever is in flight and accept nothing on this edge.
      state_r        <= ST_IDLE;
      cnt_r          <= {CW{1'b0}};
      wb_valid_r     <= 1'b0;
      wb_reg_write_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ex_valid && ex_mem_op_s) begin
            // Both read and write set is handled as a store.
            state_r        <= ST_BUSY;
            cnt_r          <= CNT_INIT;
            addr_r         <= ex_alu_result;
            store_data_r   <= ex_store_data;
            rd_r           <= ex_rd;
            load_r         <= ex_mem_read & ~ex_mem_write;
            store_r        <= ex_mem_write;
            mem_to_reg_r   <= ex_mem_to_reg;
            reg_write_r    <= ex_reg_write;
            wb_valid_r     <= 1'b0;
            wb_reg_write_r <= 1'b0;
          end else if (ex_valid) begin
            wb_valid_r      <= 1'b1;
            wb_read_data_r  <= 64'd0;
            wb_alu_output_r <= ex_alu_result;
            wb_write_reg_r  <= ex_rd;
            wb_mem_to_reg_r <= ex_mem_to_reg;
            wb_reg_write_r  <= ex_reg_write;
          end else begin
            wb_valid_r     <= 1'b0;
            wb_reg_write_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!finish_s) begin
            cnt_r          <= cnt_r - CW'(1);
            wb_valid_r     <= 1'b0;
            wb_reg_write_r <= 1'b0;
          end else begin
            state_r         <= ST_IDLE;
            wb_valid_r      <= 1'b1;
            wb_read_data_r  <= load_r ? load_data_s : 64'd0;
            wb_alu_output_r <= addr_r;
            wb_write_reg_r  <= rd_r;
            wb_mem_to_reg_r <= mem_to_reg_r;
            wb_reg_write_r  <= reg_write_r & ~store_r;
            if (err_s) begin
              mem_err_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          cnt_r          <= {CW{1'b0}};
          wb_valid_r     <= 1'b0;
          wb_reg_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready      = (state_r == ST_IDLE);
  assign wb_valid      = wb_valid_r;
  assign wb_read_data  = wb_read_data_r;
  assign wb_alu_output = wb_alu_output_r;
  assign wb_write_reg  = wb_write_reg_r;
  assign wb_mem_to_reg = wb_mem_to_reg_r;
  assign wb_reg_write  = wb_reg_write_r;
  assign mem_err       = mem_err_r;

endmodule
